// File: rtl/mem_bist_responder.sv
// mem_bist_responder: self-clearing word memory with a request/response port, read fault overlay and saturating access counters.
module mem_bist_responder #(
  parameter int size   = 6,
  parameter int length = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [size-1:0]   req_addr,
  input  logic [length-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [length-1:0] rsp_rdata,
  input  logic              fi_en,
  input  logic [size-1:0]   fi_addr,
  input  logic [length-1:0] fi_mask,
  input  logic [length-1:0] fi_value,
  output logic              init_done,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count
);
  localparam logic [0:0] INIT  = 1'b0;
  localparam logic [0:0] READY = 1'b1;
  logic [0:0] state_q, state_d;
  logic [size-1:0] clr_q, clr_d;
  logic rsp_valid_q, rsp_valid_d;
  logic [length-1:0] rsp_rdata_q, rsp_rdata_d, mem_rd;
  logic [15:0] wr_count_q, wr_count_d, rd_count_q, rd_count_d;
  logic [length-1:0] mem_q [2**size];
  logic wr_acc, rd_acc;
  assign init_done = state_q == READY;
  assign req_ready = init_done && (!rsp_valid_q || rsp_ready);
  assign wr_acc    = req_valid && req_ready && req_we;
  assign rd_acc    = req_valid && req_ready && !req_we;
  assign mem_rd    = mem_q[req_addr];
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign wr_count  = wr_count_q;
  assign rd_count  = rd_count_q;
  always_comb begin
    state_d     = (state_q == INIT && clr_q == '1) ? READY : state_q;
    clr_d       = (state_q == INIT) ? clr_q + 1'b1 : clr_q;
    rsp_valid_d = rd_acc || (rsp_valid_q && !rsp_ready);
    rsp_rdata_d = !rd_acc ? rsp_rdata_q :
                  (fi_en && req_addr == fi_addr) ? ((mem_rd & ~fi_mask) | (fi_value & fi_mask)) : mem_rd;
    wr_count_d  = wr_count_q + {15'd0, wr_acc && wr_count_q != '1};
    rd_count_d  = rd_count_q + {15'd0, rd_acc && rd_count_q != '1};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      clr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      wr_count_q  <= '0;
      rd_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      clr_q       <= clr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      wr_count_q  <= wr_count_d;
      rd_count_q  <= rd_count_d;
    end
  end
  // Storage has no reset; the INIT sweep zeroes it one word per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == INIT) mem_q[clr_q] <= '0;
      else if (wr_acc) mem_q[req_addr] <= req_wdata;
    end
  end
endmodule

// File: tb/tb_mem_bist_responder.sv
// tb_mem_bist_responder: directed checks of clear sequence, read/write, fault overlay, backpressure and reset.
module tb_mem_bist_responder;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_we = 0, rsp_ready = 1, fi_en = 0;
  logic [5:0] req_addr = 0, fi_addr = 0;
  logic [7:0] req_wdata = 0, fi_mask = 0, fi_value = 0;
  logic req_ready, rsp_valid, init_done;
  logic [7:0] rsp_rdata;
  logic [15:0] wr_count, rd_count;
  int vectors = 0, errs = 0, nw = 0, nr = 0;
  logic [7:0] exp_mem [64];

  mem_bist_responder #(.size(6), .length(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .fi_en(fi_en), .fi_addr(fi_addr), .fi_mask(fi_mask),
    .fi_value(fi_value), .init_done(init_done), .wr_count(wr_count), .rd_count(rd_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (!init_done && n < 200) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk({tag, "_cycles"}, n, 64);
    chk({tag, "_done"}, init_done, 1);
  endtask

  task automatic do_write(input logic [5:0] a, input logic [7:0] d);
    req_valid = 1; req_we = 1; req_addr = a; req_wdata = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0; req_we = 0;
    nw++;
  endtask

  task automatic do_read(input string tag, input logic [5:0] a, input logic [7:0] exp);
    req_valid = 1; req_we = 0; req_addr = a;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    nr++;
    chk({tag, "_valid"}, rsp_valid, 1);
    chk({tag, "_data"}, rsp_rdata, exp);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_init_done", init_done, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_req_ready", req_ready, 0);
    rst = 0;
    wait_init("init1");
    chk("ready_idle", req_ready, 1);
    // basic write then read-after-write
    do_write(6'd10, 8'hA5);
    do_read("raw10", 6'd10, 8'hA5);
    chk("wr_count1", wr_count, 1);
    chk("rd_count1", rd_count, 1);
    do_read("clear5", 6'd5, 8'h00);
    // fault overlay
    do_write(6'd3, 8'hFF);
    fi_en = 1; fi_addr = 6'd3; fi_mask = 8'h0F; fi_value = 8'h00;
    do_read("fi_on", 6'd3, 8'hF0);
    fi_addr = 6'd4;
    do_read("fi_other", 6'd3, 8'hFF);
    fi_en = 0; fi_addr = 6'd3;
    do_read("fi_off", 6'd3, 8'hFF);
    // backpressure
    do_write(6'd1, 8'h3C);
    rsp_ready = 0;
    do_read("stall", 6'd1, 8'h3C);
    req_valid = 1; req_we = 1; req_addr = 6'd2; req_wdata = 8'h77;
    for (int i = 0; i < 5; i++) begin
      chk("stall_req_ready", req_ready, 0);
      @(posedge clk);
      @(negedge clk);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_data", rsp_rdata, 8'h3C);
    end
    req_valid = 0; req_we = 0;
    chk("stall_wr_count", wr_count, nw);
    rsp_ready = 1;
    #1 chk("release_req_ready", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    chk("release_valid", rsp_valid, 0);
    do_read("blocked_write", 6'd2, 8'h00);
    // back-to-back reads over the whole array
    for (int i = 0; i < 64; i++) begin
      exp_mem[i] = 8'(i * 37 + 11);
      do_write(6'(i), exp_mem[i]);
    end
    req_valid = 1; req_we = 0; req_addr = 6'd0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      @(negedge clk);
      nr++;
      chk("b2b_valid", rsp_valid, 1);
      chk("b2b_data", rsp_rdata, exp_mem[i]);
      if (i < 63) req_addr = 6'(i + 1);
      else req_valid = 0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("b2b_drain", rsp_valid, 0);
    chk("wr_count_total", wr_count, nw);
    chk("rd_count_total", rd_count, nr);
    // reset with a pending response
    rsp_ready = 0;
    do_read("pend", 6'd7, exp_mem[7]);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk("rst2_rsp_valid", rsp_valid, 0);
    chk("rst2_init_done", init_done, 0);
    chk("rst2_wr_count", wr_count, 0);
    chk("rst2_rd_count", rd_count, 0);
    chk("rst2_req_ready", req_ready, 0);
    rsp_ready = 1;
    wait_init("init2");
    do_read("cleared10", 6'd10, 8'h00);
    do_read("cleared63", 6'd63, 8'h00);
    chk("rst2_rd_after", rd_count, 2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/mem_bist_responder.md
MEM_BIST_RESPONDER -- requirements
Module: mem_bist_responder

Interface
REQ-001 Parameter: size, 6, address width (2**size words).
REQ-002 Parameter: length, 8, data width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder accepts request this cycle.
REQ-007 req_we  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  size  word address.
REQ-009 req_wdata  input  length  write data.
REQ-010 rsp_valid  output  1  read data valid.
REQ-011 rsp_ready  input  1  initiator accepts read data.
REQ-012 rsp_rdata  output  length  read data.
REQ-013 fi_en  input  1  fault-injection enable.
REQ-014 fi_addr  input  size  faulty word address.
REQ-015 fi_mask  input  length  stuck bit positions (1 = stuck).
REQ-016 fi_value  input  length  stuck-at values for masked bits.
REQ-017 init_done  output  1  memory clear complete, requests accepted.
REQ-018 wr_count  output  16  accepted-write count, saturating.
REQ-019 rd_count  output  16  accepted-read count, saturating.

Function
REQ-020 FSM states: INIT, READY; no other states.
REQ-021 INIT: internal 2**size-entry clear counter writes 0 to one word per cycle, addresses 0 up to 2**size-1, then moves to READY on the following cycle; INIT lasts exactly 2**size cycles.
REQ-022 INIT: req_ready = 0, init_done = 0, rsp_valid = 0.
REQ-023 READY: init_done = 1; stays in READY until rst.
REQ-024 req_ready = (state == READY) && (!rsp_valid || rsp_ready); combinational.
REQ-025 Request accepted on a cycle with req_valid && req_ready.
REQ-026 Accepted write: mem[req_addr] <= req_wdata at that edge; no response generated.
REQ-027 Accepted read: rsp_valid = 1 on the next cycle, rsp_rdata = mem[req_addr] at acceptance time, with fault overlay applied.
REQ-028 Read-after-write to the same address on consecutive accepted requests returns the new data.
REQ-029 Fault overlay: if fi_en && req_addr == fi_addr at read acceptance, rdata = (mem & ~fi_mask) | (fi_value & fi_mask); otherwise rdata = mem; stored contents never modified by fault injection.
REQ-030 rsp_valid && !rsp_ready: rsp_valid and rsp_rdata held stable; req_ready = 0.
REQ-031 rsp_valid && rsp_ready with a new accepted read in the same cycle: rsp_valid stays 1, rsp_rdata updates to new data next cycle (back-to-back reads, one per cycle).
REQ-032 rsp_valid && rsp_ready with no new read accepted: rsp_valid = 0 next cycle.
REQ-033 wr_count / rd_count increment by 1 per accepted write / read; hold at 16'hFFFF; INIT clear writes not counted.
REQ-034 req_ready independent of req_valid; no combinational path req_valid -> req_ready.

Reset
REQ-035 rst sampled high at posedge clk: state = INIT, clear counter = 0, rsp_valid = 0, rsp_rdata = 0, wr_count = 0, rd_count = 0, init_done = 0.
REQ-036 rst asserted mid-INIT or mid-READY (including with pending response): pending response discarded, full clear restarts from address 0.
REQ-037 rst held high: outputs stay at reset values, clear counter does not advance.

Verification
REQ-038 Reset release, size=6: init_done rises exactly 64 cycles after rst deasserts; read any address -> rdata = 8'h00.
REQ-039 Write 8'hA5 to addr 6'd10, read addr 10 next cycle -> rsp_valid one cycle after acceptance, rsp_rdata = 8'hA5; wr_count = 1, rd_count = 1.
REQ-040 mem[3] = 8'hFF, fi_en = 1, fi_addr = 3, fi_mask = 8'h0F, fi_value = 8'h00, read addr 3 -> 8'hF0; fi_en = 0, read again -> 8'hFF.
REQ-041 Read addr 1 with rsp_ready = 0 for 5 cycles -> rsp_valid and rsp_rdata held constant, req_ready = 0 throughout, no request accepted; rsp_ready = 1 -> completes, req_ready returns 1.
REQ-042 Back-to-back reads of addrs 0..63 with rsp_ready = 1 -> one response per cycle in address order, data matching prior writes.
REQ-043 rst pulsed one cycle while a read response is pending -> rsp_valid = 0 next cycle, init_done = 0, 64-cycle clear repeats, counters = 0, prior data reads back 8'h00.
